// File: rtl/board_sensor_scanner.sv
// board_sensor_scanner: scans the 8x4 dark-square sensor matrix one row at a time.
// It debounces whole frames and presents a stable 32-bit occupancy word.
// Optional feature macro: SENSOR_ACTIVE_LOW_EN. When it is defined, the column
// sense lines are treated as active-low.
module board_sensor_scanner #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [3:0]  col_in,
    output logic [7:0]  row_sel,
    output logic [31:0] sensor_board,
    output logic        board_valid,
    output logic        board_changed,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        COMMIT
    } state_t;

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEBOUNCE_MIN = 4'(DEBOUNCE_FRAMES);
    localparam logic [3:0] STABLE_MAX   = 4'd15;

    state_t      state;
    logic [3:0]  col_meta;
    logic [3:0]  col_s;
    logic [3:0]  col_cap;
    logic [2:0]  row;
    logic [7:0]  settle_cnt;
    logic [31:0] raw_frame;
    logic [31:0] candidate;
    logic [3:0]  stable_cnt;
    logic [31:0] next_candidate;
    logic [3:0]  next_stable;
    logic        commit_ok;

    // Two-flop synchroniser for the asynchronous column sense lines.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments. This makes every flop sample the pre-edge values.
        if (reset) begin
            col_meta <= '0;
            col_s    <= '0;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

`ifdef SENSOR_ACTIVE_LOW_EN
    assign col_cap = ~col_s;
`else
    assign col_cap = col_s;
`endif

    // Post-update debounce state, evaluated for use in the COMMIT cycle.
    always_comb begin
        // NOTE: each output gets a default first, so no path can leave it unassigned and infer a latch.
        next_candidate = raw_frame;
        next_stable    = 4'd1;
        if (raw_frame == candidate) begin
            next_candidate = candidate;
            next_stable    = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
        end
        commit_ok = (next_stable >= DEBOUNCE_MIN) &&
                    (!board_valid || (next_candidate != sensor_board));
    end

    // Scan FSM. row_sel is registered and tracks the state being entered.
    // frame_done and board_changed are registered one-cycle pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            row           <= '0;
            settle_cnt    <= '0;
            row_sel       <= '0;
            raw_frame     <= '0;
            candidate     <= '0;
            stable_cnt    <= '0;
            sensor_board  <= '0;
            board_valid   <= 1'b0;
            board_changed <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            board_changed <= 1'b0;
            case (state)
                IDLE: begin
                    row_sel <= '0;
                    if (scan_en) begin
                        state      <= DRIVE;
                        row        <= '0;
                        settle_cnt <= '0;
                        row_sel    <= 8'h01;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        raw_frame[{row, 2'b00} +: 4] <= col_cap;
                        if (row != 3'd7) begin
                            // The next row is driven on the following cycle, with no gap.
                            row        <= row + 3'd1;
                            settle_cnt <= '0;
                            row_sel    <= row_sel << 1;
                        end else begin
                            state      <= COMMIT;
                            row_sel    <= '0;
                            frame_done <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                COMMIT: begin
                    candidate  <= next_candidate;
                    stable_cnt <= next_stable;
                    if (commit_ok) begin
                        sensor_board  <= next_candidate;
                        board_valid   <= 1'b1;
                        board_changed <= 1'b1;
                    end
                    if (scan_en) begin
                        state      <= DRIVE;
                        row        <= '0;
                        settle_cnt <= '0;
                        row_sel    <= 8'h01;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    row_sel <= '0;
                end
            endcase
        end
    end

endmodule
